id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode/execute pipeline register plus operand-forwarding front end for the execute-stage ALU. Captures decoded operands and control from decode on each clock and presents `ALUop1`, `ALUop2` and `ALUctrl` to the ALU. Resolves RAW hazards by forwarding from memory and writeback, and flags load-use hazards. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `REGW`, 5: register index width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all stage registers.
- `flush`  in  1  load a bubble into the stage.
- `validD`  in  1  decode slot holds a real instruction.
- `RD1D`, `RD2D`  in  XLEN  register-file read data.
- `ImmExtD`, `PCD`  in  XLEN  extended immediate; instruction PC.
- `rs1D`, `rs2D`, `rdD`  in  REGW  source and destination indices.
- `ALUctrlD`  in  3  ALU operation code.
- `ALUsrcAD`  in  1  op1 source: 0 = rs1, 1 = PC.
- `ALUsrcBD`  in  1  op2 source: 0 = rs2, 1 = immediate.
- `RegWriteD`, `MemWriteD`, `BranchD`, `JumpD`  in  1  control bits.
- `ResultSrcD`  in  2  00 = ALU, 01 = load, 10 = PC+4.
- `rdM`, `rdW`  in  REGW  destinations in memory and writeback.
- `RegWriteM`, `RegWriteW`  in  1  write enables in memory and writeback.
- `ALUResultM`, `ResultW`  in  XLEN  forwardable values.
- `ALUop1`, `ALUop2`  out  XLEN  ALU operands.
- `ALUctrl`  out  3  ALU operation.
- `WriteDataE`  out  XLEN  forwarded rs2 value, used as store data.
- `PCE`, `ImmExtE`  out  XLEN  registered PC and immediate.
- `rdE`  out  REGW  registered destination index.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `validE`  out  1  registered control bits.
- `ResultSrcE`  out  2  registered result-source select.
- `loadUseHazard`  out  1  decode must stall one cycle.

## Operation
- Register update priority on each rising edge: `rst` > `flush` > `stall` > load from the D inputs.
- `rst` and `flush` load all registers with 0. The result is a bubble: `validE` = 0, every control bit = 0, `ALUctrl` = 000 (add).
- `stall` holds every register unchanged.
- If `flush` and `stall` are both asserted, the flush wins.
- Forwarding, applied to rs1E and rs2E independently:
  - Select the memory value if `RegWriteM` and `rdM` == rsE and rsE != 0.
  - Otherwise select the writeback value if `RegWriteW` and `rdW` == rsE and rsE != 0.
  - Otherwise use the registered `RD1`/`RD2` value.
  - Memory has priority over writeback. Register x0 is never forwarded.
- Operand selection:
  - `ALUop1` = `ALUsrcAE` ? `PCE` : fwdA.
  - `ALUop2` = `ALUsrcBE` ? `ImmExtE` : fwdB.
  - `WriteDataE` = fwdB, regardless of `ALUsrcBE`.
- `loadUseHazard` = `validE` & (`ResultSrcE` == 01) & (`rdE` != 0) & (`rdE` == `rs1D` | `rdE` == `rs2D`).
  - The hazard unit answers this with `stall` on decode and `flush` of this stage the next edge.
  - The block itself never stalls on its own.

## Timing
- Latency from D inputs to registered outputs: 1 cycle.
- `ALUop1`, `ALUop2`, `WriteDataE` and `loadUseHazard` are combinational, from registered state plus the same-cycle M/W/D inputs.
- Reset value of every output: 0, including forwarding-mux outputs while M/W are idle.
- A reset mid-operation discards the held instruction at the next edge. There is no partial state.
- A stall of N cycles keeps the outputs constant except the forwarded values. These track the M/W inputs every cycle, so a producer retiring during the stall is picked up.

## Structure
- Shared package `cpu_pkg`:
  - `ALUctrl` encodings: ADD 000, SUB 001, AND 010, OR 011, SRL 100, SLT 101, SLL 110, SRA 111.
  - `ResultSrc` encodings: ALU 00, LOAD 01, PC4 10.
  - Enum `fwd_sel_t` (REG, MEM, WB).
- Sub-module `forward_unit`: combinational, one per source operand, producing a `fwd_sel_t` from rs, rdM/rdW and RegWriteM/W.
- The pipeline register stays inline.

## Test plan
- Reset: drive `rst` high for 2 edges with nonzero D inputs -> all outputs 0, `ALUctrl` = 000.
- Forward priority:
  - `rs1D` = 5 loaded.
  - `rdM` = `rdW` = 5, both RegWrites = 1, `ALUResultM` = 0x11, `ResultW` = 0x22 -> `ALUop1` = 0x11.
  - Then `RegWriteM` = 0 -> `ALUop1` = 0x22.
  - Then `rs1` = 0 with the same M/W -> `ALUop1` = `RD1` value.
- Operand muxing:
  - `ALUsrcAD` = 1, `PCD` = 0x100, `ALUsrcBD` = 1, `ImmExtD` = 0xFFFFFFFC -> `ALUop1` = 0x100, `ALUop2` = 0xFFFFFFFC.
  - `WriteDataE` = forwarded rs2.
- Load-use:
  - Stage holds a load with `rdE` = 7, `validE` = 1; `rs2D` = 7 -> `loadUseHazard` = 1.
  - `rdE` = 0 -> `loadUseHazard` = 0.
- Stall/flush:
  - Stall 3 cycles with changing D inputs -> registered outputs unchanged.
  - `stall` and `flush` together -> bubble on the next edge.
- Back-to-back: 4 dependent adds each reading the previous rd -> every `ALUop1` equals the prior `ALUResultM`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the execute-stage front end: ALU ops, result sources, forward selects.
// No logic of its own; imported by id_ex_stage and forward_unit.
// Holds no state and never applies backpressure.
package cpu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    function automatic logic is_load(input logic [1:0] result_src);
        return result_src == RES_LOAD;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Picks the source of one execute operand: memory result, writeback result or register file.
// Combinational, zero latency.
// No backpressure; it only observes the M/W write ports.
module forward_unit
    import cpu_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output fwd_sel_t        sel
);

    // Memory is the younger producer, so it shadows writeback; x0 always reads as the register file.
    always_comb begin
        sel = FWD_REG;
        if (RegWriteM && (rdM == rs) && (rs != '0)) begin
            sel = FWD_MEM;
        end else if (RegWriteW && (rdW == rs) && (rs != '0)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with operand forwarding and load-use detection.
// One cycle D->E; operand muxes and hazard flag are combinational on registered state.
// Holds on stall, bubbles on flush (flush wins); never stalls on its own.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            validD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rdD,
    input  logic [2:0]      ALUctrlD,
    input  logic            ALUsrcAD,
    input  logic            ALUsrcBD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [1:0]      ResultSrcD,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUop1,
    output logic [XLEN-1:0] ALUop2,
    output logic [2:0]      ALUctrl,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [REGW-1:0] rdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            validE,
    output logic [1:0]      ResultSrcE,
    output logic            loadUseHazard
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [2:0]      alu_ctrl;
        logic            src_a;
        logic            src_b;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
    } ex_regs_t;

    ex_regs_t d;
    ex_regs_t q;

    always_comb begin
        d            = '0;
        d.valid      = validD;
        d.rd1        = RD1D;
        d.rd2        = RD2D;
        d.imm        = ImmExtD;
        d.pc         = PCD;
        d.rs1        = rs1D;
        d.rs2        = rs2D;
        d.rd         = rdD;
        d.alu_ctrl   = ALUctrlD;
        d.src_a      = ALUsrcAD;
        d.src_b      = ALUsrcBD;
        d.reg_write  = RegWriteD;
        d.mem_write  = MemWriteD;
        d.branch     = BranchD;
        d.jump       = JumpD;
        d.result_src = ResultSrcD;
    end

    // An all-zero register is a bubble: invalid, no side effects, ALU op = add.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    forward_unit #(.REGW(REGW)) u_fwd_a (
        .rs        (q.rs1),
        .rdM       (rdM),
        .rdW       (rdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .sel       (sel_a)
    );

    forward_unit #(.REGW(REGW)) u_fwd_b (
        .rs        (q.rs2),
        .rdM       (rdM),
        .rdW       (rdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .sel       (sel_b)
    );

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_comb begin
        case (sel_a)
            FWD_MEM: fwd_a = ALUResultM;
            FWD_WB:  fwd_a = ResultW;
            default: fwd_a = q.rd1;
        endcase
    end

    always_comb begin
        case (sel_b)
            FWD_MEM: fwd_b = ALUResultM;
            FWD_WB:  fwd_b = ResultW;
            default: fwd_b = q.rd2;
        endcase
    end

    assign ALUop1     = q.src_a ? q.pc  : fwd_a;
    assign ALUop2     = q.src_b ? q.imm : fwd_b;
    // Store data always comes from rs2, even when op2 is the immediate.
    assign WriteDataE = fwd_b;

    assign ALUctrl    = q.alu_ctrl;
    assign PCE        = q.pc;
    assign ImmExtE    = q.imm;
    assign rdE        = q.rd;
    assign RegWriteE  = q.reg_write;
    assign MemWriteE  = q.mem_write;
    assign BranchE    = q.branch;
    assign JumpE      = q.jump;
    assign validE     = q.valid;
    assign ResultSrcE = q.result_src;

    // A load's data is not forwardable from memory, so a consumer in decode must wait a cycle.
    assign loadUseHazard = q.valid && is_load(q.result_src) && (q.rd != '0)
                           && ((q.rd == rs1D) || (q.rd == rs2D));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

    logic        clk;
    logic        rst, stall, flush, validD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]  rs1D, rs2D, rdD;
    logic [2:0]  ALUctrlD;
    logic        ALUsrcAD, ALUsrcBD, RegWriteD, MemWriteD, BranchD, JumpD;
    logic [1:0]  ResultSrcD;
    logic [4:0]  rdM, rdW;
    logic        RegWriteM, RegWriteW;
    logic [31:0] ALUResultM, ResultW;
    logic [31:0] ALUop1, ALUop2, WriteDataE, PCE, ImmExtE;
    logic [2:0]  ALUctrl;
    logic [4:0]  rdE;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, validE;
    logic [1:0]  ResultSrcE;
    logic        loadUseHazard;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validD(validD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .ALUctrlD(ALUctrlD),
        .ALUsrcAD(ALUsrcAD), .ALUsrcBD(ALUsrcBD), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl), .WriteDataE(WriteDataE),
        .PCE(PCE), .ImmExtE(ImmExtE), .rdE(rdE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .validE(validE),
        .ResultSrcE(ResultSrcE), .loadUseHazard(loadUseHazard)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference model: the instruction currently held in execute.
    logic        m_valid, m_srcA, m_srcB, m_rw, m_mw, m_br, m_jp;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_ctrl;
    logic [1:0]  m_res;

    task automatic model_edge();
        if (rst || flush) begin
            {m_valid, m_srcA, m_srcB, m_rw, m_mw, m_br, m_jp} = '0;
            {m_rd1, m_rd2, m_imm, m_pc} = '0;
            {m_rs1, m_rs2, m_rd, m_ctrl, m_res} = '0;
        end else if (!stall) begin
            m_valid = validD; m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ImmExtD; m_pc = PCD;
            m_rs1 = rs1D; m_rs2 = rs2D; m_rd = rdD; m_ctrl = ALUctrlD;
            m_srcA = ALUsrcAD; m_srcB = ALUsrcBD; m_rw = RegWriteD; m_mw = MemWriteD;
            m_br = BranchD; m_jp = JumpD; m_res = ResultSrcD;
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (rs == 0) return regval;
        if (RegWriteM && rdM == rs) return ALUResultM;
        if (RegWriteW && rdW == rs) return ResultW;
        return regval;
    endfunction

    function automatic logic exp_hazard();
        return m_valid && (m_res == 2'b01) && (m_rd != 0) && (m_rd == rs1D || m_rd == rs2D);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; validD = 0;
        RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; rs1D = 0; rs2D = 0; rdD = 0;
        ALUctrlD = 0; ALUsrcAD = 0; ALUsrcBD = 0; RegWriteD = 0; MemWriteD = 0;
        BranchD = 0; JumpD = 0; ResultSrcD = 0;
        rdM = 0; rdW = 0; RegWriteM = 0; RegWriteW = 0; ALUResultM = 0; ResultW = 0;
    endtask

    task automatic rand_d();
        validD = 1'($urandom); RD1D = $urandom; RD2D = $urandom;
        ImmExtD = $urandom; PCD = $urandom;
        rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
        rdD = 5'($urandom_range(0, 3)); ALUctrlD = 3'($urandom);
        ALUsrcAD = 1'($urandom); ALUsrcBD = 1'($urandom); RegWriteD = 1'($urandom);
        MemWriteD = 1'($urandom); BranchD = 1'($urandom); JumpD = 1'($urandom);
        ResultSrcD = 2'($urandom_range(0, 2));
    endtask

    task automatic test_reset();
        idle_inputs();
        rand_d();
        validD = 1; ALUctrlD = 3'b111; RegWriteD = 1; MemWriteD = 1; BranchD = 1; JumpD = 1;
        ResultSrcD = 2'b01; rdD = 5'd9;
        rst = 1;
        tick();
        tick();
        checks++;
        if ({ALUop1, ALUop2, WriteDataE, PCE, ImmExtE} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h %h expected all 0", ALUop1, ALUop2, WriteDataE, PCE, ImmExtE);
        end
        checks++;
        if ({ALUctrl, rdE, RegWriteE, MemWriteE, BranchE, JumpE, validE, ResultSrcE, loadUseHazard} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got ctrl=%b rd=%0d rw=%b mw=%b br=%b j=%b v=%b rs=%b lu=%b expected all 0",
                     ALUctrl, rdE, RegWriteE, MemWriteE, BranchE, JumpE, validE, ResultSrcE, loadUseHazard);
        end
        rst = 0;
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        validD = 1; rs1D = 5; RD1D = 32'hAAAA_0001;
        tick();
        rdM = 5; rdW = 5; RegWriteM = 1; RegWriteW = 1; ALUResultM = 32'h11; ResultW = 32'h22;
        #1;
        checks++;
        if (ALUop1 !== 32'h11) begin
            errors++;
            $display("FAIL fwd_mem_priority: got %h expected %h", ALUop1, 32'h11);
        end
        RegWriteM = 0;
        #1;
        checks++;
        if (ALUop1 !== 32'h22) begin
            errors++;
            $display("FAIL fwd_wb: got %h expected %h", ALUop1, 32'h22);
        end
        RegWriteM = 1; rdM = 0; rdW = 0;
        rs1D = 0; RD1D = 32'hBBBB_0002;
        tick();
        checks++;
        if (ALUop1 !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL fwd_x0: got %h expected %h", ALUop1, 32'hBBBB_0002);
        end
    endtask

    task automatic test_operand_mux();
        idle_inputs();
        validD = 1; ALUsrcAD = 1; PCD = 32'h100; ALUsrcBD = 1; ImmExtD = 32'hFFFF_FFFC;
        rs1D = 4; RD1D = 32'h44; rs2D = 9; RD2D = 32'h55;
        tick();
        RegWriteM = 1; rdM = 9; ALUResultM = 32'h77; RegWriteW = 1; rdW = 4; ResultW = 32'h99;
        #1;
        checks++;
        if (ALUop1 !== 32'h100) begin
            errors++;
            $display("FAIL mux_op1_pc: got %h expected %h", ALUop1, 32'h100);
        end
        checks++;
        if (ALUop2 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL mux_op2_imm: got %h expected %h", ALUop2, 32'hFFFF_FFFC);
        end
        checks++;
        if (WriteDataE !== 32'h77) begin
            errors++;
            $display("FAIL store_data_fwd: got %h expected %h", WriteDataE, 32'h77);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        validD = 1; ResultSrcD = 2'b01; rdD = 7; RegWriteD = 1;
        tick();
        rs1D = 3; rs2D = 7;
        #1;
        checks++;
        if (loadUseHazard !== 1'b1) begin
            errors++;
            $display("FAIL load_use_rs2: got %b expected 1", loadUseHazard);
        end
        rs1D = 7; rs2D = 0;
        #1;
        checks++;
        if (loadUseHazard !== 1'b1) begin
            errors++;
            $display("FAIL load_use_rs1: got %b expected 1", loadUseHazard);
        end
        rs1D = 2; rs2D = 2;
        #1;
        checks++;
        if (loadUseHazard !== 1'b0) begin
            errors++;
            $display("FAIL load_use_nomatch: got %b expected 0", loadUseHazard);
        end
        rdD = 0;
        tick();
        rs1D = 0; rs2D = 0;
        #1;
        checks++;
        if (loadUseHazard !== 1'b0) begin
            errors++;
            $display("FAIL load_use_rd0: got %b expected 0", loadUseHazard);
        end
        validD = 0; rdD = 7;
        tick();
        rs2D = 7;
        #1;
        checks++;
        if (loadUseHazard !== 1'b0) begin
            errors++;
            $display("FAIL load_use_invalid: got %b expected 0", loadUseHazard);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] s_pc, s_imm;
        logic [4:0]  s_rd;
        logic [2:0]  s_ctrl;
        idle_inputs();
        rand_d();
        validD = 1; rs1D = 2; ALUsrcAD = 0; RegWriteD = 1;
        tick();
        s_pc = m_pc; s_imm = m_imm; s_rd = m_rd; s_ctrl = m_ctrl;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            RegWriteW = 1; rdW = 2; ResultW = $urandom;
            tick();
            checks++;
            if ({PCE, ImmExtE, rdE, ALUctrl, validE} !== {s_pc, s_imm, s_rd, s_ctrl, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got pc=%h imm=%h rd=%0d ctrl=%b v=%b expected pc=%h imm=%h rd=%0d ctrl=%b v=1",
                         i, PCE, ImmExtE, rdE, ALUctrl, validE, s_pc, s_imm, s_rd, s_ctrl);
            end
            checks++;
            if (ALUop1 !== ResultW) begin
                errors++;
                $display("FAIL stall_fwd_track[%0d]: got %h expected %h", i, ALUop1, ResultW);
            end
        end
        flush = 1;
        tick();
        checks++;
        if ({validE, RegWriteE, MemWriteE, BranchE, JumpE, ALUctrl, PCE, rdE} !== '0) begin
            errors++;
            $display("FAIL stall_flush_bubble: got v=%b rw=%b mw=%b br=%b j=%b ctrl=%b pc=%h rd=%0d expected all 0",
                     validE, RegWriteE, MemWriteE, BranchE, JumpE, ALUctrl, PCE, rdE);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  prev_rd;
        logic [31:0] resm;
        idle_inputs();
        prev_rd = 10;
        for (int i = 0; i < 4; i++) begin
            validD = 1; ALUctrlD = 3'b000; RegWriteD = 1;
            rs1D = prev_rd; rdD = 5'(11 + i); RD1D = $urandom; RD2D = $urandom;
            tick();
            resm = $urandom;
            RegWriteM = 1; rdM = prev_rd; ALUResultM = resm;
            RegWriteW = 1; rdW = prev_rd; ResultW = ~resm;
            #1;
            checks++;
            if (ALUop1 !== resm) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, ALUop1, resm);
            end
            prev_rd = rdD;
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2, ew;
        idle_inputs();
        for (int n = 0; n < 300; n++) begin
            rand_d();
            rst   = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            rdM = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            ALUResultM = $urandom; ResultW = $urandom;
            #1;
            e1 = m_srcA ? m_pc : fwd(m_rs1, m_rd1);
            e2 = m_srcB ? m_imm : fwd(m_rs2, m_rd2);
            ew = fwd(m_rs2, m_rd2);
            checks++;
            if ({ALUop1, ALUop2, WriteDataE} !== {e1, e2, ew}) begin
                errors++;
                $display("FAIL rand_operands[%0d]: got %h %h %h expected %h %h %h", n, ALUop1, ALUop2, WriteDataE, e1, e2, ew);
            end
            checks++;
            if ({PCE, ImmExtE, rdE, ALUctrl, RegWriteE, MemWriteE, BranchE, JumpE, validE, ResultSrcE} !==
                {m_pc, m_imm, m_rd, m_ctrl, m_rw, m_mw, m_br, m_jp, m_valid, m_res}) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got pc=%h imm=%h rd=%0d ctrl=%b v=%b expected pc=%h imm=%h rd=%0d ctrl=%b v=%b",
                         n, PCE, ImmExtE, rdE, ALUctrl, validE, m_pc, m_imm, m_rd, m_ctrl, m_valid);
            end
            checks++;
            if (loadUseHazard !== exp_hazard()) begin
                errors++;
                $display("FAIL rand_hazard[%0d]: got %b expected %b", n, loadUseHazard, exp_hazard());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_forward_priority();
        test_operand_mux();
        test_load_use();
        test_stall_flush();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
